cycle_sequencer: RTL
====================

Name: cycle_sequencer

Overview:
Generates the 8-subcycle instruction timing (A1,A2,A3,M1,M2,X1,X2,X3) and the sync strobe that drive the cpu, rom and ram chips in system. Adds debug run control: halt at an instruction boundary, single-step one instruction cycle, resume. Keeps a count of retired instruction cycles. Sits beside the cpu inside system and gates every chip's phase advance.

Parameters:
COUNT_WIDTH, 32, width of instr_count.
RESET_FLUSH_CYCLES, 1, number of full 8-subcycle cycles run with flushing asserted after reset release.

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low; sampled on posedge clock; 0 = reset
halt_req  input  1  level; request to stop at the next instruction boundary
step  input  1  single-clock pulse; run exactly one instruction cycle while halted
advance  output  1  1 = subcycle counter advances this clock; chips latch phase work only when 1
phase  output  8  one-hot current subcycle, bit0=A1 .. bit7=X3; all zero when halted
phase_idx  output  3  encoded current subcycle, 0=A1 .. 7=X3
sync  output  1  1 during X3 while advancing (marks the next clock as A1)
halted  output  1  1 while in HALTED
flushing  output  1  1 during post-reset flush cycles
instr_count  output  COUNT_WIDTH  number of completed X3 subcycles since reset (flush excluded)

Behaviour:
- Reset (reset==0 at posedge): state=FLUSH, phase_idx=0, flush counter=0, instr_count=0. Outputs during reset and the first clock after it: advance=1, phase=8'h01, sync=0, halted=0, flushing=1.
- States: FLUSH, RUN, DRAIN, HALTED, STEP.
- phase_idx increments mod 8 on every clock where advance=1; advance=1 in FLUSH, RUN, DRAIN and STEP, 0 in HALTED.
- phase = 1<<phase_idx when advance=1, else 8'h00. sync = advance && phase_idx==7.
- FLUSH: runs RESET_FLUSH_CYCLES full cycles; at the last X3 go to RUN, or to DRAIN→HALTED behaviour if halt_req=1 (the transition goes directly to HALTED, because the X3 boundary is reached). Flush X3s do not increment instr_count. halt_req and step are ignored except at that final X3.
- RUN: at X3, instr_count += 1. If halt_req=1 at X3, go to HALTED at the next clock. If halt_req rises mid-cycle, go to DRAIN.
- DRAIN: continue advancing to X3, increment instr_count, then HALTED. If halt_req drops before X3, return to RUN with no stop.
- HALTED: phase_idx held at 0 (A1 resumes next); advance=0; halted=1. If halt_req=0, go to RUN on the next clock. If step=1 and halt_req=1, go to STEP.
- STEP: exactly 8 advancing clocks, A1..X3. instr_count += 1 at X3. Return to HALTED if halt_req=1 at X3, else RUN. step pulses during STEP are ignored, not queued.
- halt_req and step both high in HALTED: step wins.
- instr_count wraps from all-ones to 0 with no flag.
- Reset asserted in any state, mid-cycle included, re-enters FLUSH on the next clock and discards any pending halt or step.
- Latency: halt_req high at A1 in RUN gives halted=1 exactly 8 clocks later. step pulse gives advance=1 on the next clock.

Optional Feature:
Macro CYCLE_SEQUENCER_BREAKPOINT_EN.
- Defined: adds ports bp_valid (input, 1), bp_addr (input, 12), pc (input, 12, current cpu pc) and bp_hit (output, 1).
  - At X3 in RUN, if bp_valid && pc==bp_addr: enter HALTED as if halt_req were high, set bp_hit=1.
  - bp_hit is sticky and clears on reset or on leaving HALTED.
  - STEP never triggers a breakpoint, so stepping off a breakpoint works.
- Not defined: these ports and all related logic are absent; behaviour is exactly as above.

Test Plan:
- Reset held 2 clocks, then released, halt_req=0, step=0 → phase walks 01,02,..,80 for the flush cycle with flushing=1; sync high only at X3; instr_count=0 at 9th clock, then 1 after the next X3.
- In RUN, halt_req=1 asserted at M1 (phase_idx=3) → advance continues until X3, then halted=1, phase=8'h00; instr_count increments exactly once.
- Halted, pulse step one clock → exactly 8 advance clocks, sync once, instr_count +1, halted=1 again on the 9th clock.
- Halted, step=1 and halt_req=0 on the same clock → STEP taken (8 clocks), then RUN since halt_req=0; no second halt.
- reset=0 during STEP at phase_idx=5 → next clock phase=8'h01, flushing=1, instr_count=0, halted=0.
- With CYCLE_SEQUENCER_BREAKPOINT_EN: bp_addr=12'h004, bp_valid=1, pc reaches 12'h004 at X3 → halted=1, bp_hit=1. Then a step → pc advances, no re-hit on the same address, and bp_hit clears when HALTED is left.

Source files
------------

// File: rtl/cycle_sequencer.sv
// Eight-subcycle instruction timing generator (A1..X3) with halt/step run control and retired-instruction count.
// Optional breakpoint compare enabled by defining CYCLE_SEQUENCER_BREAKPOINT_EN.
module cycle_sequencer #(
   parameter int unsigned COUNT_WIDTH        = 32,
   parameter int unsigned RESET_FLUSH_CYCLES = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   halt_req,
   input  logic                   step,
`ifdef CYCLE_SEQUENCER_BREAKPOINT_EN
   input  logic                   bp_valid,
   input  logic [11:0]            bp_addr,
   input  logic [11:0]            pc,
   output logic                   bp_hit,
`endif
   output logic                   advance,
   output logic [7:0]             phase,
   output logic [2:0]             phase_idx,
   output logic                   sync,
   output logic                   halted,
   output logic                   flushing,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   localparam int unsigned FLUSH_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(RESET_FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_FLUSH,
      S_RUN,
      S_DRAIN,
      S_HALTED,
      S_STEP
   } state_e;

   state_e                 state_q, state_d;
   logic [2:0]             idx_q, idx_d;
   logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   advance_c;
   logic                   at_x3_c;
   logic                   bp_match_c;
   logic                   bp_hold_c;

`ifdef CYCLE_SEQUENCER_BREAKPOINT_EN
   logic bp_hit_q, bp_hit_d;
   assign bp_match_c = bp_valid && (pc == bp_addr);
   // A breakpoint keeps the sequencer parked until a step moves it off.
   assign bp_hold_c  = bp_hit_q;
   assign bp_hit     = bp_hit_q;
`else
   assign bp_match_c = 1'b0;
   assign bp_hold_c  = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_FLUSH;
         idx_q       <= 3'd0;
         flush_cnt_q <= '0;
         count_q     <= '0;
`ifdef CYCLE_SEQUENCER_BREAKPOINT_EN
         bp_hit_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         flush_cnt_q <= flush_cnt_d;
         count_q     <= count_d;
`ifdef CYCLE_SEQUENCER_BREAKPOINT_EN
         bp_hit_q    <= bp_hit_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      flush_cnt_d = flush_cnt_q;
      count_d     = count_q;
`ifdef CYCLE_SEQUENCER_BREAKPOINT_EN
      bp_hit_d    = bp_hit_q;
`endif
      advance_c   = (state_q != S_HALTED);
      at_x3_c     = (idx_q == 3'd7);

      if (advance_c) begin
         idx_d = idx_q + 3'd1;
      end

      case (state_q)
         S_FLUSH: begin
            if (at_x3_c) begin
               if (flush_cnt_q == FLUSH_LAST) begin
                  flush_cnt_d = '0;
                  state_d     = halt_req ? S_HALTED : S_RUN;
               end else begin
                  flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
               end
            end
         end
         S_RUN, S_DRAIN: begin
            if (at_x3_c) begin
               count_d = count_q + COUNT_WIDTH'(1);
               state_d = (halt_req || bp_match_c) ? S_HALTED : S_RUN;
`ifdef CYCLE_SEQUENCER_BREAKPOINT_EN
               if (bp_match_c) bp_hit_d = 1'b1;
`endif
            end else begin
               state_d = halt_req ? S_DRAIN : S_RUN;
            end
         end
         S_HALTED: begin
            idx_d = 3'd0;
            if (step) begin
               state_d = S_STEP;
            end else if (!halt_req && !bp_hold_c) begin
               state_d = S_RUN;
            end
         end
         S_STEP: begin
            if (at_x3_c) begin
               count_d = count_q + COUNT_WIDTH'(1);
               state_d = halt_req ? S_HALTED : S_RUN;
            end
         end
         default: begin
            state_d = S_FLUSH;
            idx_d   = 3'd0;
         end
      endcase

`ifdef CYCLE_SEQUENCER_BREAKPOINT_EN
      if ((state_q == S_HALTED) && (state_d != S_HALTED)) bp_hit_d = 1'b0;
`endif
   end

   // Outputs are pure decodes of the state flops.
   assign advance     = advance_c;
   assign phase       = advance_c ? (8'h01 << idx_q) : 8'h00;
   assign phase_idx   = idx_q;
   assign sync        = advance_c && at_x3_c;
   assign halted      = (state_q == S_HALTED);
   assign flushing    = (state_q == S_FLUSH);
   assign instr_count = count_q;

endmodule
